// File: rtl/diff_operator_pkg.sv
// Shared constants and helpers for the unlimited-sampling recovery chain.
// The difference and antidifferentiation stages both take their default sample width from here.
package diff_operator_pkg;

    localparam int unsigned OUT_RES_DEF = 16;

    function automatic int unsigned cnt_width(input int unsigned order);
        return $clog2(order + 1);
    endfunction

endpackage

// File: rtl/diff_operator_if.sv
// Sample-in / result-out bundle of the difference operator.
// The source drives en/x and must respect busy.
interface diff_operator_if
    import diff_operator_pkg::*;
#(
    parameter int unsigned OUT_RES = OUT_RES_DEF
);
    logic                      en;
    logic signed [OUT_RES-1:0] x;
    logic signed [OUT_RES-1:0] out;
    logic                      out_valid;
    logic                      busy;
    logic                      primed;

    modport master (output en, x, input out, out_valid, busy, primed);
    modport slave  (input en, x, output out, out_valid, busy, primed);
endinterface

// File: rtl/diff_operator.sv
// Sequential ORDER-th finite difference: one subtract-and-update step per clock on hist[cnt].
// Arithmetic wraps mod 2^OUT_RES on purpose; modulo-domain differences rely on it.
module diff_operator
    import diff_operator_pkg::*;
#(
    parameter int unsigned OUT_RES = OUT_RES_DEF,
    parameter int unsigned ORDER   = 2,
    parameter int unsigned CNT_W   = cnt_width(ORDER)
) (
    input logic            clk,
    input logic            reset,
    diff_operator_if.slave bus
);
    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [CNT_W-1:0] LastStage = CNT_W'(ORDER - 1);
    localparam logic [CNT_W-1:0] FillMax   = CNT_W'(ORDER);

    state_e                    state_q;
    logic signed [OUT_RES-1:0] cur_q;
    logic signed [OUT_RES-1:0] hist_q [ORDER];
    logic        [CNT_W-1:0]   cnt_q;
    logic        [CNT_W-1:0]   fill_q;
    logic signed [OUT_RES-1:0] out_q;
    logic                      out_valid_q;
    logic                      busy_q;
    logic                      primed_q;

    logic signed [OUT_RES-1:0] hist_sel;
    logic signed [OUT_RES-1:0] nxt;

    always_comb begin
        hist_sel = '0;
        for (int k = 0; k < ORDER; k++) begin
            if (cnt_q == CNT_W'(k)) hist_sel = hist_q[k];
        end
        nxt = cur_q - hist_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_q       <= '0;
            cnt_q       <= '0;
            fill_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            primed_q    <= 1'b0;
            for (int k = 0; k < ORDER; k++) hist_q[k] <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.en) begin
                        cur_q   <= bus.x;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    for (int k = 0; k < ORDER; k++) begin
                        if (cnt_q == CNT_W'(k)) hist_q[k] <= cur_q;
                    end
                    if (cnt_q == LastStage) begin
                        out_q       <= nxt;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                        // primed reflects the history depth before this result is counted
                        primed_q    <= (fill_q == FillMax);
                        if (fill_q != FillMax) fill_q <= fill_q + 1'b1;
                    end else begin
                        cur_q <= nxt;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.primed    = primed_q;

endmodule

// File: tb/tb_diff_operator.sv
// Directed bench for diff_operator: 8-bit ORDER=2 and ORDER=1 instances,
// plus a round trip through an integrator-cascade model.
module tb_diff_operator;

    logic clk;
    logic reset;

    diff_operator_if #(.OUT_RES(8)) bus2 ();
    diff_operator_if #(.OUT_RES(8)) bus1 ();

    diff_operator #(.OUT_RES(8), .ORDER(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    diff_operator #(.OUT_RES(8), .ORDER(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        bus2.en = 1'b0;
        bus1.en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Returns result, primed and the number of edges from acceptance to out_valid.
    task automatic feed2(input logic signed [7:0] xv, output logic signed [7:0] o,
                         output logic p, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (bus2.busy && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        bus2.en = 1'b1;
        bus2.x  = xv;
        @(negedge clk);
        bus2.en = 1'b0;
        lat = 0;
        while (!bus2.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        o = bus2.out;
        p = bus2.primed;
    endtask

    task automatic feed1(input logic signed [7:0] xv, output logic signed [7:0] o);
        int lat;
        @(negedge clk);
        bus1.en = 1'b1;
        bus1.x  = xv;
        @(negedge clk);
        bus1.en = 1'b0;
        lat = 0;
        while (!bus1.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        o = bus1.out;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    logic signed [7:0] o;
    logic              p;
    int                lat;
    logic signed [7:0] sq_x [5]   = '{0, 1, 4, 9, 16};
    logic signed [7:0] sq_o [5]   = '{0, 1, 2, 2, 2};
    logic              sq_p [5]   = '{0, 0, 1, 1, 1};
    logic signed [7:0] imp_x [6]  = '{0, 0, 5, 0, 0, 0};
    logic signed [7:0] imp_o [6]  = '{0, 0, 5, -10, 5, 0};
    logic signed [7:0] held_o [4] = '{0, 3, 0, 0};
    int                npulse;
    int                last_pulse;
    logic signed [7:0] rx;
    logic signed [7:0] s1;
    logic signed [7:0] s2;
    int                rt_err;

    initial begin
        reset   = 1'b1;
        bus2.en = 1'b0;
        bus2.x  = '0;
        bus1.en = 1'b0;
        bus1.x  = '0;
        do_reset();
        @(negedge clk);
        check("rst_out", bus2.out, 0);
        check("rst_out_valid", {31'd0, bus2.out_valid}, 0);
        check("rst_busy", {31'd0, bus2.busy}, 0);
        check("rst_primed", {31'd0, bus2.primed}, 0);

        // Squares: second difference settles to 2
        for (int i = 0; i < 5; i++) begin
            feed2(sq_x[i], o, p, lat);
            check($sformatf("sq_out%0d", i), o, sq_o[i]);
            check($sformatf("sq_primed%0d", i), {31'd0, p}, {31'd0, sq_p[i]});
            if (i == 0) check("sq_latency", lat, 2);
        end

        do_reset();
        for (int i = 0; i < 6; i++) begin
            feed2(imp_x[i], o, p, lat);
            check($sformatf("imp_out%0d", i), o, imp_o[i]);
        end

        // ORDER=1 wrap: -128 - 127 = 1 mod 256
        do_reset();
        feed1(8'sd127, o);
        check("wrap_first", o, 127);
        feed1(-8'sd128, o);
        check("wrap_second", o, 1);

        // en held high with x = cycle index: samples 0,3,6,9 accepted, the rest dropped
        do_reset();
        npulse     = 0;
        last_pulse = -1;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c > 0 && bus2.out_valid) begin
                if (npulse < 4) check($sformatf("held_out%0d", npulse), bus2.out, held_o[npulse]);
                if (last_pulse >= 0) check($sformatf("held_gap%0d", npulse), c - last_pulse, 3);
                last_pulse = c;
                npulse++;
            end
            bus2.en = (c < 12);
            bus2.x  = 8'(c);
        end
        check("held_pulses", npulse, 4);

        // History is x=6,9: d1=20-9=11, d2=11-3=8
        feed2(8'sd20, o, p, lat);
        check("post_held_out", o, 8);
        check("post_held_primed", {31'd0, p}, 1);

        // Reset one edge into a RUN
        @(negedge clk);
        bus2.en = 1'b1;
        bus2.x  = 8'sd50;
        @(negedge clk);
        bus2.en = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_out", bus2.out, 0);
        check("midrst_out_valid", {31'd0, bus2.out_valid}, 0);
        check("midrst_busy", {31'd0, bus2.busy}, 0);
        check("midrst_primed", {31'd0, bus2.primed}, 0);
        npulse = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus2.out_valid) npulse++;
        end
        check("midrst_no_pulse", npulse, 0);
        feed2(8'sd7, o, p, lat);
        check("midrst_next_out", o, 7);
        check("midrst_next_primed", {31'd0, p}, 0);

        // Round trip through a two-stage integrator cascade
        do_reset();
        s1     = '0;
        s2     = '0;
        rt_err = 0;
        for (int i = 0; i < 1000; i++) begin
            rx = 8'($urandom);
            feed2(rx, o, p, lat);
            s1 = s1 + o;
            s2 = s2 + s1;
            if (s2 !== rx) rt_err++;
        end
        check("roundtrip_errors", rt_err, 0);
        check("roundtrip_last", s2, rx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
